// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   ADDR_W, DATA_W : PC / memory address width and instruction word width
//   RESET_PC       : PC loaded on reset
//   fetch_entry_t  : one prefetch buffer entry, {pc, instr}
package fetch_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH-entry register FIFO of fetch_entry_t.
//   clk, rst_n : clock, async active-low reset (clears pointers, count and entries)
//   push       : write wr_data at the tail (accepted when not full, or full with a pop)
//   pop        : advance the head (ignored when empty)
//   flush      : drop all entries; wins over push/pop
//   wr_data    : entry to write
//   head       : entry at the read pointer, straight from the registers
//   count      : occupied entries
//   full/empty : occupancy flags
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  fetch_entry_t      wr_data,
   output fetch_entry_t      head,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty
);

   fetch_entry_t     entries [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             push_en;
   logic             pop_en;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign pop_en  = pop & ~empty;
   // A full buffer can take a new entry only if the head leaves in the same cycle.
   assign push_en = push & (~full | pop_en);
   assign head    = entries[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_en) begin
            entries[wr_ptr] <= wr_data;
            wr_ptr          <= wr_ptr + PTR_W'(1);
         end
         if (pop_en) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push_en) - CNT_W'(pop_en);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage in front of a combinational instruction memory.
// Holds the PC, drives the memory address, buffers {pc, instr} pairs and
// hands them to decode over a valid/ready handshake.
//   clk, rst_n      : clock, async active-low reset
//   mem_addr        : memory address (current PC)
//   mem_data        : memory read data for mem_addr, same cycle
//   halt            : stop fetching; buffered entries still drain
//   redirect_valid  : load redirect_target into the PC and flush the buffer
//   redirect_target : new PC
//   out_valid/ready : handshake with decode
//   out_instr/pc    : head entry of the buffer
//   buf_count       : occupied buffer entries
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              halt,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instr,
   output logic [ADDR_W-1:0] out_pc,
   output logic [CNT_W-1:0]  buf_count
);

   logic [ADDR_W-1:0] pc;
   fetch_entry_t      head;
   fetch_entry_t      wr_entry;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;

   // Hiding the head during a redirect keeps a stale entry from being
   // accepted in the same cycle the buffer is flushed.
   assign out_valid = ~empty & ~redirect_valid;
   assign pop       = out_valid & out_ready;
   assign push      = ~halt & ~redirect_valid & (~full | pop);

   assign mem_addr  = pc;
   assign wr_entry  = {pc, mem_data};
   assign out_instr = head.instr;
   assign out_pc    = head.pc;

   // The PC advances only when its word is actually captured, so halt and
   // backpressure never skip or repeat an address. Wrap at 2^ADDR_W is silent.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= redirect_target;
      end else if (push) begin
         pc <= pc + ADDR_W'(1);
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (push),
      .pop     (pop),
      .flush   (redirect_valid),
      .wr_data (wr_entry),
      .head    (head),
      .count   (buf_count),
      .full    (full),
      .empty   (empty)
   );

endmodule
